// File: rtl/bcd_para_binario_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one step/clk).
// Ports: clk, rst_n (sync, active-low), iniciar, bcd_entrada -> ocupado, pronto, erro, binario.
module bcd_para_binario_seq #(
  parameter int DIGITOS     = 2,
  parameter int LARGURA_BIN = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iniciar,
  input  logic [4*DIGITOS-1:0]   bcd_entrada,
  output logic                   ocupado,
  output logic                   pronto,
  output logic                   erro,
  output logic [LARGURA_BIN-1:0] binario
);

  localparam int LB = 4 * DIGITOS;
  localparam int W  = LB + LARGURA_BIN;
  localparam int CW = $clog2(LARGURA_BIN + 1);

  typedef enum logic {
    OCIOSO,
    CONVERTE
  } estado_t;

  estado_t r_estado, w_prox;

  logic [W-1:0]           r_s, w_s_prox;
  logic [W-1:0]           w_desloc, w_corr;
  logic [CW-1:0]          r_cnt, w_cnt_prox;
  logic                   r_ocupado, w_ocupado;
  logic                   r_pronto, w_pronto;
  logic                   r_erro, w_erro;
  logic [LARGURA_BIN-1:0] r_bin, w_bin;
  logic                   w_invalido;
  logic                   w_ultimo;

  always_comb begin
    w_invalido = 1'b0;
    for (int i = 0; i < DIGITOS; i++) begin
      if (bcd_entrada[4*i +: 4] > 4'd9) begin
        w_invalido = 1'b1;
      end
    end
  end

  // Shift first, then undo the "add 3" of forward double-dabble
  // on every BCD nibble that now holds 8 or more.
  always_comb begin
    w_desloc = r_s >> 1;
    w_corr   = w_desloc;
    for (int i = 0; i < DIGITOS; i++) begin
      if (w_desloc[LARGURA_BIN+4*i +: 4] >= 4'd8) begin
        w_corr[LARGURA_BIN+4*i +: 4] =
          w_desloc[LARGURA_BIN+4*i +: 4] - 4'd3;
      end
    end
  end

  assign w_ultimo = (r_cnt == CW'(LARGURA_BIN - 1));

  always_comb begin
    w_prox     = r_estado;
    w_s_prox   = r_s;
    w_cnt_prox = r_cnt;
    w_ocupado  = r_ocupado;
    w_pronto   = 1'b0;
    w_erro     = r_erro;
    w_bin      = r_bin;
    unique case (r_estado)
      OCIOSO: begin
        if (iniciar) begin
          if (w_invalido) begin
            w_pronto = 1'b1;
            w_erro   = 1'b1;
            w_bin    = '0;
          end else begin
            w_s_prox   = {bcd_entrada, {LARGURA_BIN{1'b0}}};
            w_cnt_prox = '0;
            w_prox     = CONVERTE;
            w_ocupado  = 1'b1;
            w_erro     = 1'b0;
          end
        end
      end
      CONVERTE: begin
        w_s_prox   = w_corr;
        w_cnt_prox = r_cnt + CW'(1);
        if (w_ultimo) begin
          w_bin     = w_desloc[LARGURA_BIN-1:0];
          w_pronto  = 1'b1;
          w_ocupado = 1'b0;
          w_prox    = OCIOSO;
        end
      end
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado  <= OCIOSO;
      r_s       <= '0;
      r_cnt     <= '0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
      r_erro    <= 1'b0;
      r_bin     <= '0;
    end else begin
      r_estado  <= w_prox;
      r_s       <= w_s_prox;
      r_cnt     <= w_cnt_prox;
      r_ocupado <= w_ocupado;
      r_pronto  <= w_pronto;
      r_erro    <= w_erro;
      r_bin     <= w_bin;
    end
  end

  assign ocupado = r_ocupado;
  assign pronto  = r_pronto;
  assign erro    = r_erro;
  assign binario = r_bin;

endmodule

// File: tb/tb_bcd_para_binario_seq.sv
// Testbench for bcd_para_binario_seq: vector table, scoreboard, corner cases.
// Drives both the default build and a DIGITOS=3/LARGURA_BIN=10 build.
module tb_bcd_para_binario_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iniciar;
  logic [7:0] bcd_entrada;
  logic       ocupado, pronto, erro;
  logic [7:0] binario;

  logic        iniciar3;
  logic [11:0] bcd3;
  logic        ocupado3, pronto3, erro3;
  logic [9:0]  binario3;

  bcd_para_binario_seq u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iniciar     (iniciar),
    .bcd_entrada (bcd_entrada),
    .ocupado     (ocupado),
    .pronto      (pronto),
    .erro        (erro),
    .binario     (binario)
  );

  bcd_para_binario_seq #(
    .DIGITOS     (3),
    .LARGURA_BIN (10)
  ) u_dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .iniciar     (iniciar3),
    .bcd_entrada (bcd3),
    .ocupado     (ocupado3),
    .pronto      (pronto3),
    .erro        (erro3),
    .binario     (binario3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bin;
    logic       erro;
    int         lat;
  } exp_t;

  typedef struct {
    logic [7:0] bcd;
    logic [7:0] bin;
    logic       erro;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t tab[7];

  int n_chk    = 0;
  int n_fail   = 0;
  int n_pronto = 0;
  int busy_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (ocupado) busy_cnt++;
      if (pronto) begin
        n_pronto++;
        chk("pronto_ocupado_excl", int'(ocupado), 0);
        chk("pronto_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("binario", int'(binario), int'(e.bin));
          chk("erro", int'(erro), int'(e.erro));
          chk("latency", busy_cnt, e.lat);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input logic [7:0] b, input logic [7:0] r,
                       input logic er, input bit push);
    exp_t x;
    x.bin  = r;
    x.erro = er;
    x.lat  = er ? 0 : 8;
    iniciar     = 1'b1;
    bcd_entrada = b;
    if (push) sb.push_back(x);
    tick();
    iniciar = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk("done_in_time", sb.size(), 0);
    sb.delete();
  endtask

  function automatic logic [7:0] ref_bin(input logic [7:0] b);
    return 8'(b[7:4] * 10 + b[3:0]);
  endfunction

  initial begin
    int snap;
    int busy;
    int k;
    logic [11:0] v3[2];
    int          r3[2];

    tab[0] = '{8'h42, 8'h2A, 1'b0};
    tab[1] = '{8'h99, 8'h63, 1'b0};
    tab[2] = '{8'h00, 8'h00, 1'b0};
    tab[3] = '{8'h09, 8'h09, 1'b0};
    tab[4] = '{8'hA5, 8'h00, 1'b1};
    tab[5] = '{8'h17, 8'h11, 1'b0};
    tab[6] = '{8'h5F, 8'h00, 1'b1};

    rst_n       = 1'b0;
    iniciar     = 1'b1;
    bcd_entrada = 8'h42;
    iniciar3    = 1'b0;
    bcd3        = '0;
    repeat (2) begin
      tick();
      chk("rst_ocupado", int'(ocupado), 0);
      chk("rst_pronto", int'(pronto), 0);
      chk("rst_erro", int'(erro), 0);
      chk("rst_binario", int'(binario), 0);
    end
    rst_n   = 1'b1;
    iniciar = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      start(tab[i].bcd, tab[i].bin, tab[i].erro, 1'b1);
      wait_done();
      tick();
      chk("erro_held", int'(erro), int'(tab[i].erro));
      chk("binario_held", int'(binario), int'(tab[i].bin));
    end

    start(8'h25, 8'h19, 1'b0, 1'b1);
    repeat (3) tick();
    chk("busy_4th", int'(ocupado), 1);
    start(8'h88, 8'h00, 1'b0, 1'b0);
    wait_done();
    snap = n_pronto;
    repeat (12) tick();
    chk("no_second_conv", n_pronto, snap);

    start(8'h77, 8'h4D, 1'b0, 1'b1);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    sb.delete();
    chk("abort_ocupado", int'(ocupado), 0);
    chk("abort_pronto", int'(pronto), 0);
    chk("abort_binario", int'(binario), 0);
    rst_n = 1'b1;
    snap  = n_pronto;
    repeat (12) tick();
    chk("abort_no_pronto", n_pronto, snap);
    start(8'h31, 8'h1F, 1'b0, 1'b1);
    wait_done();

    start(8'h12, 8'h0C, 1'b0, 1'b1);
    k = 0;
    while (!pronto && k < 20) begin
      tick();
      k++;
    end
    chk("b2b_first_pronto", int'(pronto), 1);
    start(8'h34, 8'h22, 1'b0, 1'b1);
    chk("b2b_no_gap", int'(ocupado), 1);
    wait_done();
    tick();

    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        logic [7:0] b;
        b = {4'(t), 4'(u)};
        start(b, ref_bin(b), 1'b0, 1'b1);
        wait_done();
      end
    end

    v3[0] = 12'h999; r3[0] = 999;
    v3[1] = 12'h305; r3[1] = 305;
    for (int i = 0; i < 2; i++) begin
      iniciar3 = 1'b1;
      bcd3     = v3[i];
      tick();
      iniciar3 = 1'b0;
      busy = 0;
      k    = 0;
      while (!pronto3 && k < 30) begin
        if (ocupado3) busy++;
        tick();
        k++;
      end
      chk("d3_pronto", int'(pronto3), 1);
      chk("d3_busy_cycles", busy, 10);
      chk("d3_binario", int'(binario3), r3[i]);
      chk("d3_erro", int'(erro3), 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_para_binario_seq.md
Name: bcd_para_binario_seq

Overview:
- Sequential BCD-to-binary converter. It is the inverse of the team's combinational binary-to-BCD block.
- Accepts a packed multi-digit BCD word and returns its binary value using reverse double-dabble: one right-shift/correct step per clock.
- Feeds operator-entered decimal values (keypad/switch digits) back into the binary datapath.
- Uses a start/busy/done handshake with invalid-digit detection.

Parameters:
- DIGITOS, 2, number of BCD digits accepted. Legal range 1..3.
- LARGURA_BIN, 8, binary output width. Must satisfy 2^LARGURA_BIN > 10^DIGITOS - 1. Also sets the iteration count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- iniciar  input  1  start request. Sampled only in OCIOSO.
- bcd_entrada  input  4*DIGITOS  packed BCD. [3:0] = units, [7:4] = tens, etc.
- ocupado  output  1  high while a conversion is in progress.
- pronto  output  1  one-cycle pulse: binario/erro are valid.
- erro  output  1  last request contained a digit >9. Held until the next accepted start.
- binario  output  LARGURA_BIN  converted value. Held until the next completion.

Behaviour:
- Reset: single clk and synchronous active-low reset. On any rising clk edge with rst_n=0:
  - state=OCIOSO.
  - ocupado=0, pronto=0, erro=0, binario=0.
  - iteration counter=0, internal shift register=0.
  - Reset mid-conversion aborts with no pronto pulse.
- States: OCIOSO, CONVERTE.
- OCIOSO, iniciar=1 at an edge:
  - Capture bcd_entrada.
  - If any nibble >9: stay OCIOSO. Next cycle pronto=1, erro=1, binario=0, ocupado stays 0. Latency 1.
  - Otherwise: load shift register S={bcd_entrada, LARGURA_BIN zeros}, counter=0, state=CONVERTE, ocupado=1, erro=0.
- CONVERTE, each edge:
  - S = S >> 1, zero fill at MSB.
  - Then, in the BCD field of the shifted S, every nibble >=8 has 3 subtracted (4-bit, no borrow across nibbles).
  - Counter increments.
- Final iteration (counter==LARGURA_BIN-1):
  - binario <= low LARGURA_BIN bits of the shifted S. Correction on the final step is irrelevant to the result.
  - pronto=1 for exactly one cycle, ocupado=0, state=OCIOSO.
- Latency for a valid start: pronto is high in the cycle following the LARGURA_BIN-th edge after the accepting edge. Default: ocupado high 8 cycles, pronto on cycle 9.
- iniciar while ocupado=1: ignored, no queuing. bcd_entrada may change freely after the accepting edge.
- iniciar=1 in the pronto cycle (state OCIOSO): accepted. Back-to-back throughput = LARGURA_BIN+1 cycles.
- pronto and ocupado are never high simultaneously.
- Outputs are all registered. No combinational input-to-output path.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with iniciar=1 -> ocupado=0, pronto=0, erro=0, binario=0 throughout.
- Normal conversions, default params:
  - bcd_entrada=8'h42 -> ocupado high 8 cycles, then pronto pulse with binario=8'h2A, erro=0.
  - 8'h99 -> 8'h63.
  - 8'h00 -> 8'h00.
  - 8'h09 -> 8'h09.
- Invalid digit: bcd_entrada=8'hA5, iniciar=1 -> next cycle pronto=1, erro=1, binario=0, ocupado never high.
  - A subsequent valid 8'h17 clears erro and gives binario=8'h11.
- Start during busy: start 8'h25, pulse iniciar again with 8'h88 on the 4th busy cycle -> single pronto with binario=8'h19. No second conversion.
- Reset mid-operation: start 8'h77, drop rst_n on the 3rd busy cycle -> ocupado=0, no pronto, binario=0.
  - The next start with 8'h31 gives 8'h1F at normal latency.
- Back-to-back and parameter sweep:
  - Assert iniciar in the pronto cycle -> second conversion starts with no idle gap.
  - Exhaustive 00..99 comparison against a reference model.
  - Repeat with DIGITOS=3, LARGURA_BIN=10: 12'h999 -> 10'd999 after 10 busy cycles.
